// File: rtl/global_param.sv
// global_param: project-wide widths shared by the dispatcher and its neighbours
package global_param;
    parameter int INST_W = 64;
endpackage

// File: rtl/ins_dispatch.sv
// ins_dispatch: decodes one instruction at a time and routes it to the load/save
// engines, the PE array (start/done) or a sync barrier, counting retirements.
module ins_dispatch #(
    parameter int PE_NUM = 32,
    parameter int INST_W = global_param::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [INST_W-1:0] ins,
    output logic              ld_ins_valid,
    input  logic              ld_ins_ready,
    output logic [INST_W-1:0] ld_ins,
    output logic              sv_ins_valid,
    input  logic              sv_ins_ready,
    output logic [INST_W-1:0] sv_ins,
    input  logic              ld_busy,
    input  logic              sv_busy,
    output logic [PE_NUM-1:0] start,
    input  logic [PE_NUM-1:0] done,
    output logic [2:0]        mode,
    output logic [15:0]       ins_cnt,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, ISSUE_LD, ISSUE_SV, CALC_WAIT, SYNC_WAIT} state_t;

    state_t            state, state_nx;
    logic [INST_W-1:0] ir;
    logic [PE_NUM-1:0] done_seen, in_mask, ir_mask;
    logic [3:0]        op;
    logic              accept, calc_done, retire;

    assign op        = ins[INST_W-1 -: 4];
    assign in_mask   = ins[PE_NUM-1:0];
    assign ir_mask   = ir[PE_NUM-1:0];
    assign accept    = ins_valid && state == IDLE;
    assign calc_done = (done_seen | (done & ir_mask)) == ir_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ir        <= '0;
            start     <= '0;
            mode      <= '0;
            done_seen <= '0;
            ins_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            start <= '0;
            if (accept)
                ir <= ins;
            if (accept && op == 4'd2) begin
                mode      <= ins[PE_NUM+2:PE_NUM];
                start     <= in_mask;
                done_seen <= '0;
            end else if (state == CALC_WAIT)
                done_seen <= done_seen | (done & ir_mask);
            if (retire)
                ins_cnt <= ins_cnt + 16'd1;
            if (accept && op > 4'd4)
                err <= 1'b1;
        end
    end

    // NOP, illegal opcodes and empty-mask CALC fall through and stay in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (ins_valid)
                           state_nx = op == 4'd1 ? ISSUE_LD :
                                      op == 4'd3 ? ISSUE_SV :
                                      op == 4'd2 && |in_mask ? CALC_WAIT :
                                      op == 4'd4 ? SYNC_WAIT : IDLE;
            ISSUE_LD:  if (ld_ins_ready) state_nx = IDLE;
            ISSUE_SV:  if (sv_ins_ready) state_nx = IDLE;
            CALC_WAIT: if (calc_done) state_nx = IDLE;
            SYNC_WAIT: if (!ld_busy && !sv_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // every path back into IDLE, including the in-place ones, retires the instruction
    always_comb begin
        ins_ready    = state == IDLE;
        ld_ins_valid = state == ISSUE_LD;
        sv_ins_valid = state == ISSUE_SV;
        ld_ins       = ld_ins_valid ? ir : '0;
        sv_ins       = sv_ins_valid ? ir : '0;
        retire       = (state != IDLE || accept) && state_nx == IDLE;
    end
endmodule

// File: tb/tb_ins_dispatch.sv
// tb_ins_dispatch: randomized and directed stimulus against a queue-based model;
// a negedge monitor pops expected handshakes, start pulses and retirements.
module tb_ins_dispatch;
    localparam int PN = 32;
    localparam int IW = global_param::INST_W;

    logic          clk = 1'b0, rst = 1'b1;
    logic          ins_valid = 1'b0, ins_ready;
    logic [IW-1:0] ins = '0, ld_ins, sv_ins;
    logic          ld_ins_valid, ld_ins_ready = 1'b0, sv_ins_valid, sv_ins_ready = 1'b0;
    logic          ld_busy = 1'b0, sv_busy = 1'b0;
    logic [PN-1:0] start, done = '0;
    logic [2:0]    mode;
    logic [15:0]   ins_cnt;
    logic          err;

    ins_dispatch #(.PE_NUM(PN), .INST_W(IW)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .ld_ins_valid(ld_ins_valid), .ld_ins_ready(ld_ins_ready), .ld_ins(ld_ins),
        .sv_ins_valid(sv_ins_valid), .sv_ins_ready(sv_ins_ready), .sv_ins(sv_ins),
        .ld_busy(ld_busy), .sv_busy(sv_busy),
        .start(start), .done(done), .mode(mode),
        .ins_cnt(ins_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared = 0, mismatched = 0;

    typedef struct {logic [15:0] cnt; logic err; logic [2:0] mode; int due;} ret_t;
    typedef struct {logic [PN-1:0] mask; logic [2:0] mode; int due;} st_t;
    ret_t          ret_q[$];
    st_t           st_q[$];
    logic [IW-1:0] ld_q[$], sv_q[$];
    logic [15:0]   m_cnt = '0;
    logic          m_err = 1'b0;
    logic [2:0]    m_mode = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // monitor: compares whatever the DUT presents against the expectation queues
    logic [15:0] prev_cnt = '0;
    bit          skip = 1'b0;
    st_t         s;
    ret_t        r;
    always @(negedge clk) begin
        if (rst)
            skip = 1'b1;
        else if (skip) begin
            skip = 1'b0;
            prev_cnt = ins_cnt;
        end else begin
            if (ld_ins_valid) begin
                if (ld_q.size() == 0) chk("ld_unexpected", 64'(ld_ins_valid), 64'(0));
                else begin
                    chk("ld_ins", 64'(ld_ins), 64'(ld_q[0]));
                    if (ld_ins_ready) void'(ld_q.pop_front());
                end
            end
            if (sv_ins_valid) begin
                if (sv_q.size() == 0) chk("sv_unexpected", 64'(sv_ins_valid), 64'(0));
                else begin
                    chk("sv_ins", 64'(sv_ins), 64'(sv_q[0]));
                    if (sv_ins_ready) void'(sv_q.pop_front());
                end
            end
            if (start != '0) begin
                if (st_q.size() == 0) chk("start_unexpected", 64'(start), 64'(0));
                else begin
                    s = st_q.pop_front();
                    chk("start_mask", 64'(start), 64'(s.mask));
                    chk("start_mode", 64'(mode), 64'(s.mode));
                    chk("start_cycle", 64'(cyc), 64'(s.due));
                end
            end
            if (ins_cnt != prev_cnt) begin
                if (ret_q.size() == 0) chk("retire_unexpected", 64'(ins_cnt), 64'(prev_cnt));
                else begin
                    r = ret_q.pop_front();
                    chk("ins_cnt", 64'(ins_cnt), 64'(r.cnt));
                    chk("err", 64'(err), 64'(r.err));
                    chk("retire_mode", 64'(mode), 64'(r.mode));
                    chk("retire_cycle", 64'(cyc), 64'(r.due));
                end
            end else if (ret_q.size() != 0 && cyc > ret_q[0].due) begin
                chk("retire_late", 64'(cyc), 64'(ret_q[0].due));
                void'(ret_q.pop_front());
            end
            prev_cnt = ins_cnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_at(input int due);
        m_cnt++;
        ret_q.push_back('{m_cnt, m_err, m_mode, due});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ret_q.delete(); st_q.delete(); ld_q.delete(); sv_q.delete();
        m_cnt = '0; m_err = 1'b0; m_mode = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ins_ready", 64'(ins_ready), 64'(1));
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_ins_cnt", 64'(ins_cnt), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_mode", 64'(mode), 64'(0));
        chk("rst_valids", 64'({ld_ins_valid, sv_ins_valid}), 64'(0));
        chk("rst_ld_ins", 64'(ld_ins), 64'(0));
        chk("rst_sv_ins", 64'(sv_ins), 64'(0));
    endtask

    // present one instruction for its accept cycle and record what it must cause
    task automatic send(input logic [IW-1:0] x);
        logic [3:0] op;
        op = x[IW-1 -: 4];
        chk("ins_ready_idle", 64'(ins_ready), 64'(1));
        ins_valid = 1'b1;
        ins = x;
        ld_busy = 1'($urandom_range(0, 1));
        sv_busy = 1'($urandom_range(0, 1));
        case (op)
            4'd1: ld_q.push_back(x);
            4'd3: sv_q.push_back(x);
            4'd4: ;
            4'd2: begin
                m_mode = x[PN+2:PN];
                if (x[PN-1:0] != '0) st_q.push_back('{x[PN-1:0], m_mode, cyc + 1});
                else retire_at(cyc + 1);
            end
            default: begin
                if (op > 4'd4) m_err = 1'b1;
                retire_at(cyc + 1);
            end
        endcase
        step();
        ins_valid = 1'b0;
        ins = {$urandom, $urandom};
    endtask

    task automatic wait_io(input bit sv, input int stall);
        logic go;
        for (int i = 0; ; i++) begin
            go = stall < 0 ? ($urandom_range(0, 2) == 0 || i > 40) : (i == stall);
            ld_ins_ready = !sv && go;
            sv_ins_ready = sv && go;
            chk("ins_ready_busy", 64'(ins_ready), 64'(0));
            chk(sv ? "sv_valid_held" : "ld_valid_held", 64'(sv ? sv_ins_valid : ld_ins_valid), 64'(1));
            if (go) begin
                retire_at(cyc + 1);
                step();
                ld_ins_ready = 1'b0;
                sv_ins_ready = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic wait_calc(input logic [PN-1:0] mask);
        logic [PN-1:0] rem, d;
        rem = mask;
        for (int i = 0; ; i++) begin
            d = i > 30 ? rem : ($urandom & rem);
            done = d | ($urandom & ~mask);
            rem &= ~d;
            chk("ins_ready_calc", 64'(ins_ready), 64'(0));
            chk("mode_held", 64'(mode), 64'(m_mode));
            if (rem == '0) begin
                retire_at(cyc + 1);
                step();
                done = '0;
                break;
            end
            step();
        end
    endtask

    task automatic wait_sync(input int lb, input int sb);
        for (int i = 0; ; i++) begin
            ld_busy = lb < 0 ? 1'($urandom_range(0, 1)) && i < 40 : i < lb;
            sv_busy = sb < 0 ? 1'($urandom_range(0, 1)) && i < 40 : i < sb;
            chk("ins_ready_sync", 64'(ins_ready), 64'(0));
            if (!ld_busy && !sv_busy) begin
                retire_at(cyc + 1);
                step();
                break;
            end
            step();
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [2:0] md, input logic [PN-1:0] mask);
        logic [IW-1:0] x;
        x = {$urandom, $urandom};
        x[IW-1 -: 4] = op;
        x[PN+2:PN] = md;
        x[PN-1:0] = mask;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] x;
        logic [3:0]    op;
        int            k;
        #1;
        do_reset();
        // LOAD with five stalled cycles
        send(mk(4'd1, 3'd0, '0));
        wait_io(1'b0, 5);
        chk("load_cnt", 64'(ins_cnt), 64'(1));
        // CALC mask 5 mode 3 with staggered done, one outside the mask
        send(mk(4'd2, 3'd3, 32'h5));
        for (int i = 0; i < 5; i++) begin
            done = i == 0 ? 32'h1 : i == 2 ? 32'h2 : i == 4 ? 32'h4 : 32'h0;
            chk("calc_mode", 64'(mode), 64'(3));
            chk("calc_ready", 64'(ins_ready), 64'(0));
            if (i == 4) retire_at(cyc + 1);
            step();
        end
        done = '0;
        chk("calc_mode_after", 64'(mode), 64'(3));
        // SYNC behind busy engines
        send(mk(4'd4, 3'd0, '0));
        wait_sync(10, 12);
        // illegal then NOP back-to-back
        send(mk(4'd7, 3'd0, 32'hFF));
        send(mk(4'd0, 3'd0, 32'hFF));
        chk("err_set", 64'(err), 64'(1));
        step();
        step();
        chk("err_sticky", 64'(err), 64'(1));
        // reset in the middle of a CALC, then an empty-mask CALC
        send(mk(4'd2, 3'd5, 32'hF0));
        step();
        step();
        do_reset();
        send(mk(4'd2, 3'd6, '0));
        step();
        chk("calc0_cnt", 64'(ins_cnt), 64'(1));
        chk("calc0_mode", 64'(mode), 64'(6));
        // randomized traffic
        repeat (200) begin
            k = $urandom_range(0, 9);
            op = k == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            x = mk(op, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3) == 0 ? '0 : $urandom_range(0, 1) ? $urandom : PN'(1) << $urandom_range(0, PN - 1));
            send(x);
            case (op)
                4'd1: wait_io(1'b0, -1);
                4'd3: wait_io(1'b1, -1);
                4'd2: if (x[PN-1:0] != '0) wait_calc(x[PN-1:0]);
                4'd4: wait_sync(-1, -1);
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (5) step();
        chk("ret_q_empty", 64'(ret_q.size()), 64'(0));
        chk("st_q_empty", 64'(st_q.size()), 64'(0));
        chk("ld_q_empty", 64'(ld_q.size()), 64'(0));
        chk("sv_q_empty", 64'(sv_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ins_dispatch.md
INS_DISPATCH -- requirements
Module: ins_dispatch

Interface
REQ-001 SHALL take parameter PE_NUM, default 32: number of PEs; sets the width of the start, done and mask fields.
REQ-002 SHALL take parameter INST_W, default from package GLOBAL_PARAM: instruction width; SHALL satisfy INST_W >= PE_NUM+7.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ins_valid / ins_ready / ins  in / out / in  1 / 1 / INST_W  upstream instruction stream, valid/ready.
REQ-006 ld_ins_valid / ld_ins_ready / ld_ins  out / in / out  1 / 1 / INST_W  LOAD channel to ddr2pe.
REQ-007 sv_ins_valid / sv_ins_ready / sv_ins  out / in / out  1 / 1 / INST_W  SAVE channel to pe2ddr.
REQ-008 ld_busy, sv_busy  in  1 each  load engine / save engine has work outstanding.
REQ-009 start  out  PE_NUM  per-PE one-cycle start pulse; done  in  PE_NUM  per-PE done pulse.
REQ-010 mode  out  3  PE mode; held stable from the start pulse until CALC completion.
REQ-011 ins_cnt  out  16  count of retired instructions, wraps; err  out  1  sticky illegal-opcode flag.

Function
REQ-012 Fields: opcode = ins[INST_W-1 -: 4]; mode = ins[PE_NUM+2:PE_NUM]; pe_mask = ins[PE_NUM-1:0].
REQ-013 Opcodes: 0 NOP, 1 LOAD, 2 CALC, 3 SAVE, 4 SYNC; all others are illegal.
REQ-014 FSM states: IDLE, ISSUE_LD, ISSUE_SV, CALC_WAIT, SYNC_WAIT.
REQ-015 ins_ready SHALL equal 1 only in IDLE; an accept (ins_valid & ins_ready) SHALL latch ins into the instruction register.
REQ-016 Accepted NOP: stay in IDLE; ins_cnt +1 on the next cycle.
REQ-017 Accepted illegal opcode: treated as NOP; err set to 1 on the next cycle and held until rst.
REQ-018 Accepted LOAD: go to ISSUE_LD; ld_ins_valid=1 and ld_ins=latched instruction from the next cycle.
REQ-019 In ISSUE_LD: hold ld_ins_valid and ld_ins stable until ld_ins_ready=1; on that handshake, return to IDLE and retire.
REQ-020 SAVE: same behaviour as LOAD, using ISSUE_SV and the sv_* channel.
REQ-021 Accepted CALC with pe_mask != 0, entering CALC_WAIT:
- start = pe_mask for exactly one cycle (the cycle after accept).
- mode = latched mode.
- done_seen register cleared.
REQ-022 In CALC_WAIT:
- done_seen |= done & pe_mask; done bits outside pe_mask are ignored.
- A done asserted in the same cycle as the start pulse counts.
REQ-023 CALC completes when (done_seen | (done & pe_mask)) == pe_mask; then go to IDLE and retire, with ins_ready=1 on the following cycle.
REQ-024 CALC with pe_mask == 0: no start pulse; retire at once (behaves as NOP apart from updating mode).
REQ-025 Accepted SYNC: go to SYNC_WAIT; return to IDLE and retire in the first cycle with ld_busy=0 and sv_busy=0; minimum 1 cycle in SYNC_WAIT.
REQ-026 Retire: ins_cnt increments by 1 in the cycle after completion; wraps 0xFFFF -> 0x0000.
REQ-027 Only one instruction is in flight; ins is not sampled outside IDLE.
REQ-028 ld_ins / sv_ins SHALL not change while their valid is high.

Reset
REQ-029 With rst=1 at a clk edge, all of the following SHALL hold from the next cycle:
- state=IDLE, ins_ready=1.
- ld_ins_valid=0, sv_ins_valid=0, start=0, mode=0.
- ins_cnt=0, err=0, done_seen=0.
- ld_ins, sv_ins=0.
REQ-030 Reset mid-operation (any state) SHALL abort the in-flight instruction without retiring it; pending valids drop the next cycle.

Verification
REQ-031 LOAD (opcode 1), ld_ins_ready held 0 for 5 cycles then 1 -> ld_ins_valid high for 6 cycles with ld_ins stable; ins_ready=0 during that time; ins_cnt=1 afterwards.
REQ-032 CALC with pe_mask=0x0000_0005, mode=3:
- Stimulus: done[0] in the start cycle, done[1] at +2, done[2] at +4.
- Required: start=0x5 for exactly 1 cycle; done[1] ignored; completion at +4; mode=3 throughout.
REQ-033 SYNC with ld_busy=1 for 10 cycles and sv_busy=1 for 12 cycles -> retire in the first cycle both are 0; ins_ready stays 0 until then.
REQ-034 Opcodes 7 then 0 back-to-back -> err=1 and stays 1; ins_cnt=2; no start pulse and no valid asserted on any channel.
REQ-035 Reset sequence:
- Stimulus: rst asserted during CALC_WAIT, then CALC with pe_mask=0.
- Required after rst: start=0, ins_cnt=0, ins_ready=1.
- Required after the CALC: retires with no start pulse.
